rs_issue_sched: RTL and testbench
=================================

// Module: rs_issue_sched
// PURPOSE
//  Issue scheduler between the add/sub and mul/div reservation stations and the shared
//  operand-read/execute stage (pr3 pipeline registers).
//  Each cycle, picks at most one ready RS entry: round-robin within a class, alternating
//  between classes when both have candidates.
//  Enforces the non-pipelined mul/div unit's occupancy, and masks entries already issued
//  until the RS frees them.
// PARAMETERS
//  NUM_ADD  3  add/sub RS entries
//  NUM_MUL  3  mul/div RS entries
//  IDX_W    2  width of entry index; must satisfy 2**IDX_W >= max(NUM_ADD,NUM_MUL)
//  MUL_LAT  3  mul/div occupancy in cycles (>=1); min spacing between mul issues
// PORTS
//  clk1          in   1        system clock (single clock domain)
//  rst_n         in   1        synchronous, active-low reset
//  add_rdy       in   NUM_ADD  entry i busy and both operands available
//  mul_rdy       in   NUM_MUL  same, mul/div RS
//  iss_stall     in   1        downstream stage cannot accept an issue this cycle
//  flush         in   1        synchronous flush (mispredict), clears scheduler state
//  iss_valid     out  1        one-cycle pulse: issue presented to pr3 stage
//  iss_cls       out  1        0 = add/sub RS, 1 = mul/div RS
//  iss_idx       out  IDX_W    RS entry index being issued
//  add_clr       out  NUM_ADD  one-hot, coincident with iss_valid: mark add entry executing
//  mul_clr       out  NUM_MUL  one-hot, same for mul RS
//  mul_busy      out  1        mul/div unit occupied (mul_cnt != 0)
// BEHAVIOUR
//  Clock/reset
//   - All state changes on posedge clk1.
//   - rst_n low: iss_valid=0, iss_cls=0, iss_idx=0, add_clr=0, mul_clr=0, mul_busy=0.
//   - Reset also clears: add_ptr=0, mul_ptr=0, masks=0, mul_cnt=0, last_cls=1 (add favoured first).
//  Eligibility
//   - add_elig[i] = add_rdy[i] & ~add_mask[i].
//   - mul_elig[i] = mul_rdy[i] & ~mul_mask[i] & (mul_cnt==0).
//  Grant, decided in cycle t from inputs sampled at t
//   - No grant if iss_stall or flush.
//   - Class: if both classes eligible, pick !last_cls; otherwise whichever class has a candidate.
//   - Entry: first eligible index at or after that class's ptr, wrapping modulo NUM_x.
//  Output timing
//   - Registered, 1-cycle latency: grant at t gives iss_valid/iss_cls/iss_idx/x_clr high
//     for exactly cycle t+1.
//   - With no grant, all of these read 0 in cycle t+1; iss_cls and iss_idx are 0 whenever iss_valid=0.
//  State update on grant
//   - Class ptr <= (idx+1) mod NUM_x.
//   - last_cls <= granted class.
//   - x_mask[idx] <= 1.
//   - Mul grant only: mul_cnt <= MUL_LAT-1.
//  Masks
//   - x_mask[i] clears in any cycle where x_rdy[i]=0 (RS freed the entry).
//   - An entry held ready therefore issues once only.
//  Mul occupancy
//   - mul_cnt decrements by 1 per cycle while nonzero, saturating at 0.
//   - Consecutive mul grants are exactly >= MUL_LAT cycles apart (MUL_LAT=1 allows back-to-back).
//   - Add grants are unaffected by mul_busy.
//  Stall
//   - No grant, pointers and last_cls hold.
//   - mul_cnt still decrements.
//   - Masks still clear on rdy low.
//  Flush
//   - Same clears as reset except outputs: iss_valid etc. =0 next cycle.
//   - Flush overrides any simultaneous grant or stall.
//  Empty
//   - No eligible entries: no grant, pointers and last_cls hold.
// TESTING
//  1. rst_n low 2 cycles with add_rdy=111, mul_rdy=111
//     -> iss_valid=0 throughout.
//     Release -> first grant add idx0: iss_valid=1, iss_cls=0, add_clr=001 in the cycle after.
//  2. add_rdy held 111, mul_rdy=000
//     -> iss_idx 0,1,2 on three consecutive cycles, then no issue.
//     Drop add_rdy[1] 1 cycle, raise again -> idx1 reissued.
//  3. add_rdy=001 and mul_rdy=001 asserted in the same cycle after reset
//     -> add idx0 issued first, mul idx0 next cycle (iss_cls=1, mul_clr=001).
//  4. MUL_LAT=3, mul_rdy=011 held, add_rdy=111
//     -> mul idx0, then mul idx1 exactly 3 cycles later.
//     mul_busy=1 for the 2 cycles between; add issues occupy the gaps.
//  5. add_rdy=010 with iss_stall=1 for 2 cycles
//     -> no iss_valid; stall drops -> idx1 issued next cycle, add_ptr=2.
//  6. Mul issued (mul_cnt=2), flush asserted next cycle with mul_rdy=100
//     -> no grant that cycle, mul_busy=0 after.
//     Mul idx2 issued the following cycle.

Source files
------------

// File: rtl/rs_issue_sched.sv
// Issue scheduler: picks at most one ready entry per cycle from the add/sub and mul/div
// reservation stations, round-robin within a class and alternating between classes.
module rs_issue_sched #(
   parameter int NUM_ADD = 3,
   parameter int NUM_MUL = 3,
   parameter int IDX_W   = 2,
   parameter int MUL_LAT = 3
) (
   input  logic               clk1,
   input  logic               rst_n,
   input  logic [NUM_ADD-1:0] add_rdy,
   input  logic [NUM_MUL-1:0] mul_rdy,
   input  logic               iss_stall,
   input  logic               flush,
   output logic               iss_valid,
   output logic               iss_cls,
   output logic [IDX_W-1:0]   iss_idx,
   output logic [NUM_ADD-1:0] add_clr,
   output logic [NUM_MUL-1:0] mul_clr,
   output logic               mul_busy
);

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   logic [IDX_W-1:0]   add_ptr, mul_ptr;
   logic [NUM_ADD-1:0] add_mask;
   logic [NUM_MUL-1:0] mul_mask;
   logic [CNT_W-1:0]   mul_cnt;
   logic               last_cls;

   logic [NUM_ADD-1:0] add_elig, add_set;
   logic [NUM_MUL-1:0] mul_elig, mul_set;
   logic               add_any, mul_any, grant, gnt_cls;
   logic [IDX_W-1:0]   add_pick, mul_pick, gnt_idx, aidx, midx;
   int                 aj, mj;

   assign mul_busy = (mul_cnt != '0);

   always_comb begin
      add_elig = add_rdy & ~add_mask;
      mul_elig = mul_rdy & ~mul_mask & {NUM_MUL{mul_cnt == '0}};
      add_any  = |add_elig;
      mul_any  = |mul_elig;
      add_pick = '0;
      mul_pick = '0;
      aj       = 0;
      mj       = 0;
      aidx     = '0;
      midx     = '0;
      // Scan from the farthest offset down so the nearest eligible index after ptr wins.
      for (int k = NUM_ADD - 1; k >= 0; k--) begin
         aj = int'(add_ptr) + k;
         if (aj >= NUM_ADD) aj = aj - NUM_ADD;
         aidx = IDX_W'(aj);
         if (add_elig[aidx]) add_pick = aidx;
      end
      for (int k = NUM_MUL - 1; k >= 0; k--) begin
         mj = int'(mul_ptr) + k;
         if (mj >= NUM_MUL) mj = mj - NUM_MUL;
         midx = IDX_W'(mj);
         if (mul_elig[midx]) mul_pick = midx;
      end
      grant   = ~iss_stall & ~flush & (add_any | mul_any);
      gnt_cls = (add_any & mul_any) ? ~last_cls : mul_any;
      gnt_idx = gnt_cls ? mul_pick : add_pick;
      add_set = (grant && !gnt_cls) ? (NUM_ADD'(1) << add_pick) : '0;
      mul_set = (grant &&  gnt_cls) ? (NUM_MUL'(1) << mul_pick) : '0;
   end

   always_ff @(posedge clk1) begin
      if (!rst_n || flush) begin
         iss_valid <= 1'b0;
         iss_cls   <= 1'b0;
         iss_idx   <= '0;
         add_clr   <= '0;
         mul_clr   <= '0;
         add_ptr   <= '0;
         mul_ptr   <= '0;
         add_mask  <= '0;
         mul_mask  <= '0;
         mul_cnt   <= '0;
         last_cls  <= 1'b1;
      end else begin
         iss_valid <= grant;
         iss_cls   <= grant & gnt_cls;
         iss_idx   <= grant ? gnt_idx : '0;
         add_clr   <= add_set;
         mul_clr   <= mul_set;
         // A mask drops once the RS frees the entry (rdy low); the grant sets it.
         add_mask  <= (add_mask & add_rdy) | add_set;
         mul_mask  <= (mul_mask & mul_rdy) | mul_set;
         if (grant) begin
            last_cls <= gnt_cls;
            if (gnt_cls)
               mul_ptr <= (mul_pick == IDX_W'(NUM_MUL - 1)) ? '0 : mul_pick + IDX_W'(1);
            else
               add_ptr <= (add_pick == IDX_W'(NUM_ADD - 1)) ? '0 : add_pick + IDX_W'(1);
         end
         if (grant && gnt_cls)
            mul_cnt <= CNT_W'(MUL_LAT - 1);
         else if (mul_cnt != '0)
            mul_cnt <= mul_cnt - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: directed stimulus, a per-cycle reference model and literal pins.
module tb_rs_issue_sched;

   localparam int NUM_ADD = 3;
   localparam int NUM_MUL = 3;
   localparam int IDX_W   = 2;
   localparam int MUL_LAT = 3;

   logic               clk1;
   logic               rst_n;
   logic [NUM_ADD-1:0] add_rdy;
   logic [NUM_MUL-1:0] mul_rdy;
   logic               iss_stall;
   logic               flush;
   logic               iss_valid;
   logic               iss_cls;
   logic [IDX_W-1:0]   iss_idx;
   logic [NUM_ADD-1:0] add_clr;
   logic [NUM_MUL-1:0] mul_clr;
   logic               mul_busy;

   int n_assert = 0;
   int n_fail   = 0;

   rs_issue_sched #(
      .NUM_ADD(NUM_ADD), .NUM_MUL(NUM_MUL), .IDX_W(IDX_W), .MUL_LAT(MUL_LAT)
   ) dut (
      .clk1(clk1), .rst_n(rst_n), .add_rdy(add_rdy), .mul_rdy(mul_rdy),
      .iss_stall(iss_stall), .flush(flush), .iss_valid(iss_valid), .iss_cls(iss_cls),
      .iss_idx(iss_idx), .add_clr(add_clr), .mul_clr(mul_clr), .mul_busy(mul_busy)
   );

   // clock / reset
   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // reference model: entries issued are remembered until their rdy drops
   int  m_add_ptr, m_mul_ptr, m_cnt;
   bit  m_last;
   bit  m_amask [NUM_ADD];
   bit  m_mmask [NUM_MUL];
   bit  m_ready = 0;
   logic       e_valid, e_cls, e_busy;
   logic [7:0] e_idx, e_aclr, e_mclr;

   always @(posedge clk1) begin : model
      int ca, cm, i;
      bit use_mul;
      e_valid = 0; e_cls = 0; e_idx = 0; e_aclr = 0; e_mclr = 0;
      if (!rst_n || flush) begin
         m_add_ptr = 0; m_mul_ptr = 0; m_cnt = 0; m_last = 1;
         for (int k = 0; k < NUM_ADD; k++) m_amask[k] = 0;
         for (int k = 0; k < NUM_MUL; k++) m_mmask[k] = 0;
      end else begin
         ca = -1;
         cm = -1;
         for (int k = 0; k < NUM_ADD; k++) begin
            i = (m_add_ptr + k) % NUM_ADD;
            if (ca < 0 && add_rdy[i] && !m_amask[i]) ca = i;
         end
         for (int k = 0; k < NUM_MUL; k++) begin
            i = (m_mul_ptr + k) % NUM_MUL;
            if (cm < 0 && m_cnt == 0 && mul_rdy[i] && !m_mmask[i]) cm = i;
         end
         for (int k = 0; k < NUM_ADD; k++) if (!add_rdy[k]) m_amask[k] = 0;
         for (int k = 0; k < NUM_MUL; k++) if (!mul_rdy[k]) m_mmask[k] = 0;
         use_mul = 0;
         if (!iss_stall && (ca >= 0 || cm >= 0)) begin
            use_mul = (ca >= 0 && cm >= 0) ? !m_last : (cm >= 0);
            e_valid = 1;
            e_cls   = use_mul;
            m_last  = use_mul;
            if (use_mul) begin
               e_idx = 8'(cm);
               e_mclr = 8'(1 << cm);
               m_mmask[cm] = 1;
               m_mul_ptr = (cm + 1) % NUM_MUL;
            end else begin
               e_idx = 8'(ca);
               e_aclr = 8'(1 << ca);
               m_amask[ca] = 1;
               m_add_ptr = (ca + 1) % NUM_ADD;
            end
         end
         if (e_valid && use_mul) m_cnt = MUL_LAT - 1;
         else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end
      e_busy  = (m_cnt != 0);
      m_ready = 1;
   end

   // compare process: outputs checked on every negedge once the model has stepped
   always @(negedge clk1) begin
      if (m_ready) begin
         chk("model_valid", 8'(iss_valid), 8'(e_valid));
         chk("model_cls",   8'(iss_cls),   8'(e_cls));
         chk("model_idx",   8'(iss_idx),   e_idx);
         chk("model_add_clr", 8'(add_clr), e_aclr);
         chk("model_mul_clr", 8'(mul_clr), e_mclr);
         chk("model_busy",  8'(mul_busy),  8'(e_busy));
      end
   end

   // driver tasks
   task automatic cyc();
      @(negedge clk1);
   endtask

   task automatic drive(input logic [2:0] a, input logic [2:0] m);
      add_rdy = a;
      mul_rdy = m;
   endtask

   task automatic do_flush();
      drive(3'b000, 3'b000);
      flush = 1'b1;
      cyc();
      chk("flush_valid", 8'(iss_valid), 8'd0);
      flush = 1'b0;
   endtask

   task automatic pin(input string name, input logic v, input logic c, input logic [1:0] idx,
                      input logic [2:0] ac, input logic [2:0] mc, input logic b);
      chk({name, "_valid"}, 8'(iss_valid), 8'(v));
      chk({name, "_cls"},   8'(iss_cls),   8'(c));
      chk({name, "_idx"},   8'(iss_idx),   8'(idx));
      chk({name, "_aclr"},  8'(add_clr),   8'(ac));
      chk({name, "_mclr"},  8'(mul_clr),   8'(mc));
      chk({name, "_busy"},  8'(mul_busy),  8'(b));
   endtask

   initial begin
      rst_n = 1'b0; iss_stall = 1'b0; flush = 1'b0;
      drive(3'b111, 3'b111);
      // 1: reset held, then first grant is add idx0
      cyc(); pin("rst0", 0, 0, 0, 3'b000, 3'b000, 0);
      cyc(); pin("rst1", 0, 0, 0, 3'b000, 3'b000, 0);
      rst_n = 1'b1;
      cyc(); pin("t1_first", 1, 0, 0, 3'b001, 3'b000, 0);
      do_flush();

      // 2: round-robin over held add entries, then re-issue after release
      drive(3'b111, 3'b000);
      cyc(); pin("t2_a0", 1, 0, 0, 3'b001, 3'b000, 0);
      cyc(); pin("t2_a1", 1, 0, 1, 3'b010, 3'b000, 0);
      cyc(); pin("t2_a2", 1, 0, 2, 3'b100, 3'b000, 0);
      cyc(); pin("t2_idle", 0, 0, 0, 3'b000, 3'b000, 0);
      drive(3'b101, 3'b000);
      cyc(); pin("t2_drop", 0, 0, 0, 3'b000, 3'b000, 0);
      drive(3'b111, 3'b000);
      cyc(); pin("t2_reiss", 1, 0, 1, 3'b010, 3'b000, 0);
      cyc(); pin("t2_idle2", 0, 0, 0, 3'b000, 3'b000, 0);
      do_flush();

      // 3: simultaneous classes, add favoured first
      drive(3'b001, 3'b001);
      cyc(); pin("t3_add", 1, 0, 0, 3'b001, 3'b000, 0);
      cyc(); pin("t3_mul", 1, 1, 0, 3'b000, 3'b001, 1);
      do_flush();

      // 4: mul spacing with adds filling the gaps
      drive(3'b111, 3'b011);
      cyc(); pin("t4_add0", 1, 0, 0, 3'b001, 3'b000, 0);
      cyc(); pin("t4_mul0", 1, 1, 0, 3'b000, 3'b001, 1);
      cyc(); pin("t4_add1", 1, 0, 1, 3'b010, 3'b000, 1);
      cyc(); pin("t4_add2", 1, 0, 2, 3'b100, 3'b000, 0);
      cyc(); pin("t4_mul1", 1, 1, 1, 3'b000, 3'b010, 1);
      cyc(); pin("t4_idle", 0, 0, 0, 3'b000, 3'b000, 1);
      do_flush();

      // 5: stall holds the grant, pointer moves past the issued entry
      drive(3'b010, 3'b000);
      iss_stall = 1'b1;
      cyc(); pin("t5_st0", 0, 0, 0, 3'b000, 3'b000, 0);
      cyc(); pin("t5_st1", 0, 0, 0, 3'b000, 3'b000, 0);
      iss_stall = 1'b0;
      cyc(); pin("t5_a1", 1, 0, 1, 3'b010, 3'b000, 0);
      drive(3'b111, 3'b000);
      cyc(); pin("t5_ptr2", 1, 0, 2, 3'b100, 3'b000, 0);
      do_flush();

      // 6: flush during mul occupancy frees the unit
      drive(3'b000, 3'b001);
      cyc(); pin("t6_mul0", 1, 1, 0, 3'b000, 3'b001, 1);
      drive(3'b000, 3'b100);
      flush = 1'b1;
      cyc(); pin("t6_flush", 0, 0, 0, 3'b000, 3'b000, 0);
      flush = 1'b0;
      cyc(); pin("t6_mul2", 1, 1, 2, 3'b000, 3'b100, 1);
      do_flush();

      // flush beats a ready entry; the entry issues once flush drops
      drive(3'b001, 3'b000);
      flush = 1'b1;
      cyc(); pin("t7_flush", 0, 0, 0, 3'b000, 3'b000, 0);
      flush = 1'b0;
      cyc(); pin("t7_a0", 1, 0, 0, 3'b001, 3'b000, 0);
      drive(3'b000, 3'b000);
      cyc();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
